// File: rtl/riscv_pkg.sv
// Shared RISC-V CPU definitions: datapath width, well-known encodings and
// the instruction-fetch FSM state type.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [2:0] {
      FS_IDLE,
      FS_ISSUE,
      FS_WAIT,
      FS_FULL,
      FS_HALT
   } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry instruction buffer between fetch and decode. Flush and decode
// acceptance both empty it; a load fills it with an instruction and its PC.
module fetch_buffer
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            load_i,
   input  logic            clear_i,
   input  logic            accept_i,
   input  logic [XLEN-1:0] instr_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            valid_o,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc_q,    pc_d;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (clear_i || accept_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         instr_d = instr_i;
         pc_d    = pc_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one outstanding imem read
// at a time and hands words to decode; redirects flush buffer and in-flight data.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            instr_ready,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_fault
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            discard_q, discard_d;
   logic            fault_q, fault_d;
   logic            buf_load, buf_clear, buf_accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FS_IDLE;
         fetch_pc_q <= RESET_PC;
         discard_q  <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         discard_q  <= discard_d;
         fault_q    <= fault_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      discard_d  = discard_q;
      fault_d    = fault_q;
      buf_load   = 1'b0;
      buf_clear  = 1'b0;

      unique case (state_q)
         FS_IDLE:  state_d = FS_ISSUE;
         FS_ISSUE: state_d = FS_WAIT;
         FS_WAIT: begin
            if (imem_rvalid) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  state_d   = FS_ISSUE;
               end else begin
                  buf_load   = 1'b1;
                  fetch_pc_d = fetch_pc_q + XLEN'(4);
                  state_d    = FS_FULL;
               end
            end
         end
         FS_FULL: begin
            if (instr_ready) state_d = FS_ISSUE;
         end
         FS_HALT:  state_d = FS_HALT;
         default:  state_d = FS_IDLE;
      endcase

      // Redirect overrides everything above; a request already on the bus
      // must still be drained, hence the discard flag.
      if (redirect && (state_q != FS_HALT)) begin
         buf_load  = 1'b0;
         buf_clear = 1'b1;
         if (redirect_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = FS_HALT;
         end else begin
            fetch_pc_d = redirect_pc;
            unique case (state_q)
               FS_ISSUE: begin
                  discard_d = 1'b1;
                  state_d   = FS_WAIT;
               end
               FS_WAIT: begin
                  discard_d = !imem_rvalid;
                  state_d   = imem_rvalid ? FS_ISSUE : FS_WAIT;
               end
               default: state_d = FS_ISSUE;
            endcase
         end
      end
   end

   always_comb begin
      imem_req  = 1'b0;
      imem_addr = '0;
      if (state_q == FS_ISSUE) begin
         imem_req  = 1'b1;
         imem_addr = fetch_pc_q;
      end
   end

   assign buf_accept  = instr_valid && instr_ready;
   assign fetch_fault = fault_q;

   fetch_buffer u_buffer (
      .clk      (clk),
      .reset    (reset),
      .load_i   (buf_load),
      .clear_i  (buf_clear),
      .accept_i (buf_accept),
      .instr_i  (imem_rdata),
      .pc_i     (fetch_pc_q),
      .valid_o  (instr_valid),
      .instr_o  (instr),
      .pc_o     (instr_pc)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized phase
// checked against a program-order scoreboard and a latency-modelled memory.
module tb_fetch_unit;

   localparam logic [31:0] PAT = 32'hA5A5_0000;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   int checks   = 0;
   int failures = 0;

   int          mem_cnt  = 0;
   logic [31:0] mem_addr = '0;
   int          lat      = 1;
   bit          rand_lat = 1'b0;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .fetch_fault (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_valid(input string tag);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (instr_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"},   32'(imem_req),    32'd0);
      check({tag, "_addr"},  imem_addr,        32'd0);
      check({tag, "_valid"}, 32'(instr_valid), 32'd0);
      check({tag, "_instr"}, instr,            32'd0);
      check({tag, "_pc"},    instr_pc,         32'd0);
      check({tag, "_fault"}, 32'(fetch_fault), 32'd0);
   endtask

   // Instruction memory: answers each request after its latency with addr^PAT,
   // and flags any second request issued while one is still pending.
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clk);
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_addr ^ PAT;
            end
         end
         if (imem_req === 1'b1) begin
            check("one_outstanding", 32'(mem_cnt), 32'd0);
            mem_addr = imem_addr;
            mem_cnt  = rand_lat ? int'($urandom_range(1, 4)) : lat;
         end
      end
   end

   initial begin
      logic [31:0] a;
      logic [31:0] exp_pc;
      logic [31:0] prev_pc, prev_instr, target;
      bit          hold_prev, redir_prev, ok;
      int          accepted;

      reset       = 1'b1;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      repeat (2) step();
      check_all_zero("reset");

      // Sequential fetch with 1-cycle memory: one instruction every 3 cycles.
      lat         = 1;
      instr_ready = 1'b1;
      reset       = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 32'(4 * i);
         step();
         if (i == 2) instr_ready = 1'b0;
         check("seq_req", 32'(imem_req), 32'd1);
         check("seq_addr", imem_addr, a);
         check("seq_valid_issue", 32'(instr_valid), 32'd0);
         step();
         check("seq_req_wait", 32'(imem_req), 32'd0);
         check("seq_valid_wait", 32'(instr_valid), 32'd0);
         step();
         check("seq_valid", 32'(instr_valid), 32'd1);
         check("seq_pc", instr_pc, a);
         check("seq_instr", instr, a ^ PAT);
      end

      // Decode stall: buffer held, no new request.
      for (int i = 0; i < 10; i++) begin
         step();
         check("hold_valid", 32'(instr_valid), 32'd1);
         check("hold_pc", instr_pc, 32'h8);
         check("hold_instr", instr, 32'h8 ^ PAT);
         check("hold_req", 32'(imem_req), 32'd0);
      end
      instr_ready = 1'b1;
      lat         = 3;
      step();
      check("resume_req", 32'(imem_req), 32'd1);
      check("resume_addr", imem_addr, 32'hC);

      // Redirect while waiting on a 3-cycle response.
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      check("redir_wait_valid", 32'(instr_valid), 32'd0);
      check("redir_wait_req", 32'(imem_req), 32'd0);
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         check("no_stale", 32'(instr_valid), 32'd0);
         if (imem_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      check("redir_req_seen", 32'(ok), 32'd1);
      check("redir_addr", imem_addr, 32'h100);
      wait_valid("redir_valid_timeout");
      check("redir_pc", instr_pc, 32'h100);
      check("redir_instr", instr, 32'h100 ^ PAT);

      // Redirect together with acceptance in FULL.
      lat         = 1;
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      step();
      redirect = 1'b0;
      check("full_redir_valid", 32'(instr_valid), 32'd0);
      check("full_redir_req", 32'(imem_req), 32'd1);
      check("full_redir_addr", imem_addr, 32'h40);
      wait_valid("full_redir_timeout");
      check("full_redir_pc", instr_pc, 32'h40);
      check("full_redir_instr", instr, 32'h40 ^ PAT);

      // Misaligned target: sticky fault and halt until reset.
      instr_ready = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h102;
      step();
      check("fault_set", 32'(fetch_fault), 32'd1);
      check("fault_valid", 32'(instr_valid), 32'd0);
      check("fault_req", 32'(imem_req), 32'd0);
      for (int i = 0; i < 20; i++) begin
         redirect    = 1'b1;
         redirect_pc = $urandom & 32'hFFFF_FFFC;
         instr_ready = 1'($urandom);
         step();
         check("halt_req", 32'(imem_req), 32'd0);
         check("halt_fault", 32'(fetch_fault), 32'd1);
         check("halt_valid", 32'(instr_valid), 32'd0);
      end
      redirect    = 1'b0;
      instr_ready = 1'b1;
      reset       = 1'b1;
      step();
      check_all_zero("halt_reset");
      reset = 1'b0;
      step();
      check("restart_req", 32'(imem_req), 32'd1);
      check("restart_addr", imem_addr, 32'h0);

      // PC wrap at the top of the address space.
      wait_valid("wrap_first_timeout");
      check("wrap_first_pc", instr_pc, 32'h0);
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      check("wrap_top_req", 32'(imem_req), 32'd1);
      check("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
      wait_valid("wrap_top_timeout");
      check("wrap_top_pc", instr_pc, 32'hFFFF_FFFC);
      check("wrap_top_instr", instr, 32'hFFFF_FFFC ^ PAT);
      lat = 3;
      step();
      check("wrap_req", 32'(imem_req), 32'd1);
      check("wrap_addr", imem_addr, 32'h0);

      // Reset while waiting; the late response must be ignored.
      step();
      check("rstwait_valid", 32'(instr_valid), 32'd0);
      reset = 1'b1;
      step();
      check_all_zero("rstwait");
      reset = 1'b0;
      step();
      check("rstwait_req", 32'(imem_req), 32'd1);
      check("rstwait_addr", imem_addr, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("rstwait_late_ignored", 32'(instr_valid), 32'd0);
      end
      step();
      check("rstwait_valid_after", 32'(instr_valid), 32'd1);
      check("rstwait_pc", instr_pc, 32'h0);
      check("rstwait_instr", instr, PAT);

      // Randomized phase against the program-order scoreboard.
      reset       = 1'b1;
      instr_ready = 1'b0;
      rand_lat    = 1'b1;
      repeat (6) step();
      reset      = 1'b0;
      exp_pc     = 32'h0;
      hold_prev  = 1'b0;
      redir_prev = 1'b0;
      prev_pc    = '0;
      prev_instr = '0;
      accepted   = 0;
      for (int c = 0; c < 1500; c++) begin
         step();
         if (redir_prev) begin
            check("rnd_flush", 32'(instr_valid), 32'd0);
         end else if (hold_prev) begin
            check("rnd_hold_valid", 32'(instr_valid), 32'd1);
            check("rnd_hold_pc", instr_pc, prev_pc);
            check("rnd_hold_instr", instr, prev_instr);
         end
         if (instr_valid === 1'b1) begin
            check("rnd_pc", instr_pc, exp_pc);
            check("rnd_data", instr, instr_pc ^ PAT);
         end
         instr_ready = ($urandom_range(0, 3) != 0);
         redirect    = ($urandom_range(0, 15) == 0);
         target      = ($urandom_range(0, 7) == 0)
                       ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)
                       : ($urandom & 32'h0000_FFFC);
         redirect_pc = target;
         if (instr_valid === 1'b1 && instr_ready) begin
            exp_pc = exp_pc + 32'd4;
            accepted++;
         end
         if (redirect) exp_pc = target;
         hold_prev  = (instr_valid === 1'b1) && !instr_ready && !redirect;
         redir_prev = redirect;
         prev_pc    = instr_pc;
         prev_instr = instr;
      end
      redirect = 1'b0;
      step();
      check("rnd_fault", 32'(fetch_fault), 32'd0);
      check("rnd_progress", 32'(accepted > 50), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch unit for the RISC-V CPU: the producer side of the decode path, supplying the instruction stream whose `op`/`funct3`/`funct7b5` fields the controller decodes. It owns the fetch PC and issues one-outstanding-request reads to instruction memory with variable response latency. Fetched words are held in a single-entry buffer presented to decode with a valid/ready handshake. The controller's `PCSrc`-driven redirects (branch, jal, jalr) flush the buffer and any in-flight response.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  read request strobe; high exactly one cycle per request.
- `imem_addr`  out  32  word-aligned read address; valid when `imem_req`=1.
- `imem_rvalid`  in  1  response strobe for the single outstanding request.
- `imem_rdata`  in  32  instruction word; sampled when `imem_rvalid`=1.
- `instr_valid`  out  1  buffer holds an instruction for decode.
- `instr`  out  32  buffered instruction.
- `instr_pc`  out  32  address of `instr`.
- `instr_ready`  in  1  decode accepts `instr` this cycle.
- `redirect`  in  1  take `redirect_pc` (PCSrc from controller).
- `redirect_pc`  in  32  redirect target.
- `fetch_fault`  out  1  sticky misaligned-target flag.

## Operation
- Moore FSM, states IDLE, ISSUE, WAIT, FULL, HALT; outputs decoded from the state and buffer registers only.
- IDLE: entered on reset; → ISSUE unconditionally.
- ISSUE: `imem_req`=1, `imem_addr`=fetch_pc; → WAIT.
- WAIT: on `imem_rvalid` with discard=0, load buffer (`instr`<=rdata, `instr_pc`<=fetch_pc), fetch_pc<=fetch_pc+4 (mod 2^32, wraps silently), → FULL. With discard=1, drop the word, clear discard, → ISSUE.
- FULL: `instr_valid`=1. On `instr_valid && instr_ready`, clear the buffer and → ISSUE.
- `imem_rvalid` outside WAIT is ignored.
- Redirect, highest priority, any non-HALT state:
  - redirect_pc[1:0] != 0: `fetch_fault`<=1, clear the buffer, → HALT.
  - Otherwise fetch_pc<=redirect_pc and clear the buffer.
  - From ISSUE: the request issued this cycle still goes out; set discard, → WAIT.
  - From WAIT without `imem_rvalid` the same cycle: set discard, stay WAIT.
  - From WAIT with `imem_rvalid` the same cycle: drop the word, → ISSUE.
  - From FULL or IDLE: → ISSUE.
- Redirect together with `instr_ready` in FULL: the handshake counts as completed, and the buffer is cleared regardless.
- HALT: no requests; all inputs ignored; exit only by reset.

## Timing
- Reset (at the rising edge with `reset`=1): state=IDLE, fetch_pc=`RESET_PC`, discard=0, `imem_req`=0, `imem_addr`=0 when not requesting, `instr_valid`=0, `instr`=0, `instr_pc`=0, `fetch_fault`=0.
- Reset mid-transaction: the pending response is abandoned. A memory response arriving after reset lands in IDLE or ISSUE and is ignored.
- First request: second cycle after reset deasserts (IDLE, then ISSUE).
- With 1-cycle memory (rvalid in the cycle after `imem_req`), `instr_valid` rises 2 cycles after `imem_req`.
- Throughput: at most one instruction per 3 cycles with 1-cycle memory and `instr_ready` held high.
- Redirect latency: `instr_valid`=0 the cycle after `redirect`. Next `imem_req` to the target:
  - 1 cycle later from FULL or IDLE.
  - After the pending response from ISSUE or WAIT.
- At most one request outstanding. `instr`/`instr_pc` are stable while `instr_valid`=1 and not accepted.

## Structure
- Shared `riscv_pkg`:
  - FSM state enum.
  - `XLEN`=32.
  - `INSTR_NOP`=32'h0000_0013.
  - default `RESET_PC`.
- Single natural sub-module: `fetch_buffer`, a one-entry register (valid, instr, pc) with load/clear/accept controls. The FSM, fetch_pc and the discard flag live in `fetch_unit`.

## Test plan
- Reset with `RESET_PC`=0, 1-cycle memory returning addr^32'hA5A5_0000, `instr_ready`=1 → requests to 0, 4, 8; decode sees (`instr_pc`=0, `instr`=A5A5_0000), then 4, then 8, each 3 cycles apart.
- `instr_ready`=0 for 10 cycles while FULL → `instr`/`instr_pc` held constant; no `imem_req` issued; fetch resumes the cycle after acceptance.
- `redirect`=1, `redirect_pc`=0x100 while WAIT with 3-cycle memory → the old response is dropped; the next request goes to 0x100; `instr_pc`=0x100 is delivered; no stale word is ever valid.
- `redirect` and `instr_ready` in the same FULL cycle, `redirect_pc`=0x40 → `instr_valid`=0 next cycle; `imem_req` to 0x40 one cycle later.
- `redirect_pc`=0x102 → `fetch_fault`=1 and state HALT; no `imem_req` for 20 cycles; reset clears `fetch_fault` and fetch restarts at `RESET_PC`.
- fetch_pc at 0xFFFF_FFFC → the next request is at 0x0000_0000; `reset` asserted during WAIT → all outputs zero and the late `imem_rvalid` is ignored.
